// File: rtl/stretcher_pkg.sv
// Purpose: shared types and helpers for the pulse stretcher (and the debouncer's delay math).
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } stretch_state_t;

    // Milliseconds to clock cycles for a clock given in MHz.
    function automatic int ms_to_cycles(input int ms, input int mhz);
        return ms * mhz * 1000;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Purpose: free-running phase timer; counts up every cycle, restarts from 0 on clear.
// Latency: done is combinational from the registered count (count == done_at).
// Backpressure: none; the owner asserts clear whenever the count must restart.
// Ports: clk/rst (sync, active-high), clear (next count is 0), done_at (terminal value),
//        count (current value), done (count has reached done_at).
module cycle_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] done_at,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = clear ? '0 : count_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == done_at);

endmodule

// File: rtl/pulse_stretcher.sv
// Purpose: turns each rising edge of event_in into an ON_TIME ms pulse followed by an OFF_TIME ms gap.
// Latency: value_out/busy rise one cycle after the event edge (registered outputs).
// Backpressure: none upstream; events during a pulse/gap are queued up to MAX_PENDING, extras dropped.
// Ports: clk/rst (sync, active-high), event_in (synchronous event level), value_out (stretched pulse),
//        busy (state is not IDLE), pending (queued events).
module pulse_stretcher
    import stretcher_pkg::*;
#(
    parameter int CLK_FREQ    = 50,
    parameter int ON_TIME     = 1,
    parameter int OFF_TIME    = 1,
    parameter int MAX_PENDING = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               event_in,
    output logic                               value_out,
    output logic                               busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending
);

    localparam int ON_CYCLES  = ms_to_cycles(ON_TIME, CLK_FREQ);
    localparam int OFF_CYCLES = ms_to_cycles(OFF_TIME, CLK_FREQ);
    localparam int MAX_CYCLES = max_int(ON_CYCLES, OFF_CYCLES);
    localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int PEND_W     = $clog2(MAX_PENDING + 1);

    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PENDING);

    stretch_state_t    state_q, state_d;
    logic              value_q, value_d;
    logic              busy_q, busy_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              event_q, event_d;

    logic               evt;
    logic               timer_clear;
    logic               timer_done;
    logic [TIMER_W-1:0] timer_done_at;
    logic [TIMER_W-1:0] timer_count;
    logic               pend_inc;
    logic               pend_dec;

    // event_q resets high so a level already present at reset release is not an edge.
    assign evt     = event_in & ~event_q;
    assign event_d = event_in;

    // One timer serves both phases; only the terminal value changes.
    assign timer_done_at = (state_q == OFF) ? OFF_LAST : ON_LAST;

    cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .done_at (timer_done_at),
        .count   (timer_count),
        .done    (timer_done)
    );

    // Next-state logic. The timer is held at 0 in IDLE and restarted on every phase change.
    always_comb begin
        state_d     = state_q;
        timer_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (evt) begin
                    state_d = ON;
                end
            end
            ON: begin
                if (timer_done) begin
                    state_d     = OFF;
                    timer_clear = 1'b1;
                end
            end
            OFF: begin
                if (timer_done) begin
                    timer_clear = 1'b1;
                    state_d     = ((pending_q != '0) || evt) ? ON : IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                timer_clear = 1'b1;
            end
        endcase
    end

    // Queue bookkeeping. An edge on the last OFF cycle with an empty queue launches the
    // next pulse directly instead of being queued; otherwise a restart consumes one entry.
    always_comb begin
        pend_inc  = evt && ((state_q == ON) ||
                            ((state_q == OFF) && !(timer_done && (pending_q == '0))));
        pend_dec  = (state_q == OFF) && timer_done && (pending_q != '0);
        pending_d = pending_q;
        unique case ({pend_inc, pend_dec})
            2'b10: begin
                if (pending_q != PEND_MAX) begin
                    pending_d = pending_q + PEND_W'(1);
                end
            end
            2'b01:   pending_d = pending_q - PEND_W'(1);
            default: pending_d = pending_q;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        value_d = (state_d == ON);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            value_q   <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= '0;
            event_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
            event_q   <= event_d;
        end
    end

    // The timer must sit at zero whenever the FSM is idle.
    idle_timer_zero_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE) |-> (timer_count == '0));

    assign value_out = value_q;
    assign busy      = busy_q;
    assign pending   = pending_q;

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

- Output-side counterpart of the debouncer: turns short, fast internal events into a clean, human-visible output of guaranteed minimum duration. The debouncer removes glitches from slow mechanical inputs; this block creates slow pulses from fast ones.
- Each rising edge of `event_in` produces one high pulse of exactly ON_TIME ms on `value_out`. Every pulse is followed by an OFF_TIME ms low gap.
- Events that arrive while a pulse or gap is running are queued (saturating), so each one stays visible as a separate blink.
- Sits between bus status logic (e.g. transaction done, error) and board LEDs or test pins.

## Interface

Parameters
- `CLK_FREQ`, 50: clock frequency in MHz.
- `ON_TIME`, 1: high-pulse duration in ms.
- `OFF_TIME`, 1: minimum low gap after each pulse, in ms.
- `MAX_PENDING`, 3: queued-event capacity, ≥1.

Ports
- `clk`, input, 1: system clock, all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `event_in`, input, 1: event source; each 0→1 transition is one event.
- `value_out`, output, 1: stretched pulse output.
- `busy`, output, 1: high whenever the state is not IDLE.
- `pending`, output, $clog2(MAX_PENDING+1): number of queued events.

## Operation

- Derived constants:
  - ON_CYCLES = ON_TIME*CLK_FREQ*1000
  - OFF_CYCLES = OFF_TIME*CLK_FREQ*1000
  - The timer is wide enough for max(ON_CYCLES, OFF_CYCLES)−1.
- Edge detect:
  - `evt = event_in & ~event_q`, where `event_q` is `event_in` registered.
  - `event_q` resets to 1, so an input already high at reset release produces no event.
- FSM states: IDLE, ON, OFF.
  - IDLE: on `evt` → ON, timer←0, `value_out`←1.
  - ON: timer increments each cycle. When timer == ON_CYCLES−1 → OFF, timer←0, `value_out`←0.
  - OFF: timer increments each cycle. When timer == OFF_CYCLES−1:
    - if `pending`>0 or `evt` in this cycle → ON, timer←0, `value_out`←1;
    - otherwise → IDLE.
- Pending counter:
  - `evt` in ON or OFF increments `pending`, saturating at MAX_PENDING. Events beyond that are dropped silently.
  - The OFF→ON transition consumes a queued event: decrement `pending` when it is >0.
  - If that same cycle also has `evt`, the new event is queued, so the net change to `pending` is 0.
  - If `pending`==0 and `evt` coincides with the end of OFF, the event starts the new pulse directly and `pending` stays 0.
- `busy` is registered, consistent with the state register.

## Timing

- Reset values: state IDLE, `value_out` 0, `busy` 0, `pending` 0, timer 0, `event_q` 1.
- Latency: with `event_in` rising before posedge k, `value_out` and `busy` are high after posedge k (1 cycle, registered).
- Pulse width: `value_out` is high for exactly ON_CYCLES cycles, then low for at least OFF_CYCLES cycles.
- Re-triggers during ON do not extend the current pulse; they are only queued.
- Throughput: one pulse per ON_CYCLES+OFF_CYCLES cycles.
- `event_in` held high counts as one event. It must return low for ≥1 cycle to create another.
- Reset asserted mid-pulse: on the next edge, `value_out` drops to 0 and the queue is cleared.
- `event_in` must be synchronous to `clk`. An external pin goes through the debouncer first.

## Structure

- Package `stretcher_pkg`:
  - `typedef enum logic [1:0] {IDLE, ON, OFF} stretch_state_t`
  - function `ms_to_cycles(int ms, int mhz)`, shared with the debouncer's delay calculation.
- Natural sub-module: `cycle_timer`.
  - Parameter WIDTH.
  - Ports: `clk`, `rst`, `clear`, `count`, `done_at` (terminal value), `done`.
  - Used once for both the ON and OFF phases.
- Top level holds the FSM, edge detect and pending counter.

## Test plan

All scenarios use CLK_FREQ=1, ON_TIME=1, OFF_TIME=1 (1000 cycles each), MAX_PENDING=3.

- Single pulse: one 1-cycle `event_in` pulse → `value_out` high for exactly 1000 cycles starting 1 cycle later; `busy` drops 2000 cycles after the rise; `pending` stays 0.
- Queueing: 3 events spaced 10 cycles apart → 3 pulses of 1000 cycles separated by 1000-cycle gaps. `pending` counts 1, 2, then 1 and 0 at the starts of the 2nd and 3rd pulses.
- Saturation: 6 events during the first pulse → `pending` reaches 3 and holds; exactly 4 pulses in total.
- Coincident event: `evt` on the final OFF cycle with `pending`=0 → the next pulse starts on the following edge with no IDLE cycle and `pending` 0. The same case with `pending`=2 leaves `pending` at 2.
- Level hold and reset release: `event_in` high through reset release and held for 5000 cycles → no pulse. A later 0→1 transition gives exactly one pulse.
- Mid-pulse reset: `rst` for 1 cycle at cycle 500 of a pulse with `pending`=2 → next cycle `value_out`=0, `busy`=0, `pending`=0, and no further pulses.
